// File: rtl/strobe_period_controller.sv
`default_nettype none
// ============================================================================
// strobe_period_controller
// Paces enable pulses into a downstream strobe counter, loads its period through
// a one-entry shadow and qualifies its strobe. Optional: PERIOD_CTRL_CLAMP_EN.
// Revision: 1.0
// ============================================================================
module strobe_period_controller #(
   parameter int WIDTH = 16,
   parameter int EVT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             evt,
   input  logic [WIDTH-1:0] period_data,
   input  logic             period_valid,
   output logic             period_ready,
   input  logic             cnt_ready,
   input  logic             cnt_strobe,
   input  logic             cnt_valid,
   output logic             cnt_enable,
   output logic [WIDTH-1:0] cnt_reset_value,
   output logic             tick,
   output logic             evt_overflow,
   output logic             period_err
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2);
   localparam logic [EVT_W-1:0] PEND_MAX   = '1;

   state_t           state_q, state_d;
   logic [EVT_W-1:0] pending_q, pending_d;
   logic             shadow_full_q, shadow_full_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             cnt_enable_q, cnt_enable_d;
   logic [WIDTH-1:0] cnt_reset_value_q, cnt_reset_value_d;
   logic             tick_q, tick_d;
   logic             evt_overflow_q, evt_overflow_d;
   logic             period_err_q, period_err_d;

   logic             legal;
   logic             accept_ok;
   logic [WIDTH-1:0] period_val;
   logic             xfer;
   logic             issue;
   logic             overflow;

   assign period_ready = (state_q == IDLE) || !shadow_full_q;

   always_comb begin
      legal = (period_data >= MIN_PERIOD);
`ifdef PERIOD_CTRL_CLAMP_EN
      period_val = legal ? period_data : MIN_PERIOD;
      accept_ok  = 1'b1;
`else
      period_val = period_data;
      accept_ok  = legal;
`endif
      xfer     = period_valid && period_ready;
      // The !cnt_enable_q term guarantees a gap cycle between enables.
      issue    = (state_q == RUN) && (pending_q != '0) && cnt_ready && !cnt_enable_q;
      overflow = evt && (pending_q == PEND_MAX) && !issue;

      state_d           = state_q;
      pending_d         = pending_q;
      shadow_full_d     = shadow_full_q;
      shadow_d          = shadow_q;
      cnt_reset_value_d = cnt_reset_value_q;
      cnt_enable_d      = issue;
      tick_d            = cnt_strobe && cnt_valid;
      evt_overflow_d    = overflow;
      period_err_d      = xfer && !accept_ok;

      if (evt && !overflow && !issue) begin
         pending_d = pending_q + EVT_W'(1);
      end else if (!evt && issue) begin
         pending_d = pending_q - EVT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (xfer && accept_ok) begin
               cnt_reset_value_d = period_val;
               state_d           = RUN;
            end
         end
         RUN: begin
            // A full shadow holds period_ready low, so apply and load never coincide.
            if (shadow_full_q && cnt_strobe) begin
               cnt_reset_value_d = shadow_q;
               shadow_full_d     = 1'b0;
            end else if (xfer && accept_ok) begin
               shadow_d      = period_val;
               shadow_full_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= IDLE;
         pending_q         <= '0;
         shadow_full_q     <= 1'b0;
         shadow_q          <= '0;
         cnt_enable_q      <= 1'b0;
         cnt_reset_value_q <= '0;
         tick_q            <= 1'b0;
         evt_overflow_q    <= 1'b0;
         period_err_q      <= 1'b0;
      end else begin
         state_q           <= state_d;
         pending_q         <= pending_d;
         shadow_full_q     <= shadow_full_d;
         shadow_q          <= shadow_d;
         cnt_enable_q      <= cnt_enable_d;
         cnt_reset_value_q <= cnt_reset_value_d;
         tick_q            <= tick_d;
         evt_overflow_q    <= evt_overflow_d;
         period_err_q      <= period_err_d;
      end
   end

   assign cnt_enable      = cnt_enable_q;
   assign cnt_reset_value = cnt_reset_value_q;
   assign tick            = tick_q;
   assign evt_overflow    = evt_overflow_q;
   assign period_err      = period_err_q;

endmodule
`default_nettype wire

// File: tb/tb_strobe_period_controller.sv
`default_nettype none
// ============================================================================
// tb_strobe_period_controller
// Scoreboard bench: queue-based reference model predicts every output cycle.
// Revision: 1.0
// ============================================================================
module tb_strobe_period_controller;

   localparam int WIDTH    = 4;
   localparam int EVT_W    = 2;
   localparam int PEND_MAX = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             evt = 1'b0;
   logic [WIDTH-1:0] period_data = '0;
   logic             period_valid = 1'b0;
   logic             period_ready;
   logic             cnt_ready = 1'b0;
   logic             cnt_strobe = 1'b0;
   logic             cnt_valid = 1'b0;
   logic             cnt_enable;
   logic [WIDTH-1:0] cnt_reset_value;
   logic             tick;
   logic             evt_overflow;
   logic             period_err;

   strobe_period_controller #(.WIDTH(WIDTH), .EVT_W(EVT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .evt             (evt),
      .period_data     (period_data),
      .period_valid    (period_valid),
      .period_ready    (period_ready),
      .cnt_ready       (cnt_ready),
      .cnt_strobe      (cnt_strobe),
      .cnt_valid       (cnt_valid),
      .cnt_enable      (cnt_enable),
      .cnt_reset_value (cnt_reset_value),
      .tick            (tick),
      .evt_overflow    (evt_overflow),
      .period_err      (period_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             en;
      logic [WIDTH-1:0] crv;
      logic             tck;
      logic             ovf;
      logic             perr;
      logic             rdy;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   en_seen = 0;
   int   ovf_seen = 0;
   int   err_seen = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: pending as a saturating integer, shadow as a queue.
   int               m_pend = 0;
   bit               m_run = 0;
   bit               m_en = 0;
   logic [WIDTH-1:0] m_crv = '0;
   logic [WIDTH-1:0] m_shadow[$];

   always @(posedge clk) begin : model
      exp_t             e;
      bit               rdy, issue, ovf, perr;
      logic [WIDTH-1:0] p;
      e = '0;
      if (rst) begin
         m_pend = 0;
         m_run  = 0;
         m_en   = 0;
         m_crv  = '0;
         m_shadow.delete();
         e.rdy  = 1'b1;
      end else begin
         rdy    = !m_run || (m_shadow.size() == 0);
         issue  = m_run && (m_pend > 0) && cnt_ready && !m_en;
         ovf    = evt && (m_pend == PEND_MAX) && !issue;
         m_pend = m_pend + ((evt && !ovf) ? 1 : 0) - (issue ? 1 : 0);
         perr   = 0;
         if (period_valid && rdy) begin
            p = period_data;
            if (p < 2) begin
`ifdef PERIOD_CTRL_CLAMP_EN
               p = 2;
`else
               perr = 1;
`endif
            end
            if (!perr) begin
               if (!m_run) begin
                  m_crv = p;
                  m_run = 1;
               end else begin
                  m_shadow.push_back(p);
               end
            end
         end else if (m_run && cnt_strobe && m_shadow.size() > 0) begin
            m_crv = m_shadow.pop_front();
         end
         m_en   = issue;
         e.en   = issue;
         e.crv  = m_crv;
         e.tck  = cnt_strobe && cnt_valid;
         e.ovf  = ovf;
         e.perr = perr;
         e.rdy  = !m_run || (m_shadow.size() == 0);
      end
      sb.push_back(e);
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!rst) begin
            check("cnt_enable", cnt_enable, e.en);
            check("cnt_reset_value", cnt_reset_value, e.crv);
            check("tick", tick, e.tck);
            check("evt_overflow", evt_overflow, e.ovf);
            check("period_err", period_err, e.perr);
            check("period_ready", period_ready, e.rdy);
         end
      end
      if (!rst) begin
         if (cnt_enable)   en_seen++;
         if (evt_overflow) ovf_seen++;
         if (period_err)   err_seen++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cnt_enable"}, cnt_enable, 0);
      check({tag, "_tick"}, tick, 0);
      check({tag, "_cnt_reset_value"}, cnt_reset_value, 0);
      check({tag, "_evt_overflow"}, evt_overflow, 0);
      check({tag, "_period_err"}, period_err, 0);
      check({tag, "_period_ready"}, period_ready, 1);
   endtask

   // Reset asserted between edges; outputs must clear before the next edge.
   task automatic mid_reset();
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      step();
      rst = 1'b0;
      #1;
      check("ready_after_release", period_ready, 1);
   endtask

   int snap;
   int exp_crv;

   initial begin
      repeat (2) step();
      check_reset_outputs("por");
      rst = 1'b0;
      #1;
      check("ready_first_cycle", period_ready, 1);

      // Load period 5 from IDLE.
      period_valid = 1'b1;
      period_data  = 4'd5;
      step();
      period_valid = 1'b0;
      check("load_period5", cnt_reset_value, 5);

      // Pending saturation with the counter stalled.
      cnt_ready = 1'b0;
      snap = ovf_seen;
      for (int i = 0; i < 5; i++) begin
         evt = 1'b1;
         step();
         evt = 1'b0;
         step();
      end
      check("overflow_pulses", ovf_seen - snap, 2);
      snap = en_seen;
      cnt_ready = 1'b1;
      repeat (10) step();
      check("drain_enables", en_seen - snap, 3);

      // Illegal period offered while running.
      snap = err_seen;
      period_valid = 1'b1;
      period_data  = 4'd1;
      step();
      period_valid = 1'b0;
      cnt_strobe   = 1'b1;
      step();
      cnt_strobe   = 1'b0;
      step();
`ifdef PERIOD_CTRL_CLAMP_EN
      check("illegal_err_pulses", err_seen - snap, 0);
      exp_crv = 2;
`else
      check("illegal_err_pulses", err_seen - snap, 1);
      exp_crv = 5;
`endif
      check("illegal_crv", cnt_reset_value, exp_crv);

      // Shadow load then apply on the strobe edge.
      period_valid = 1'b1;
      period_data  = 4'd3;
      step();
      period_valid = 1'b0;
      check("shadow_full_ready", period_ready, 0);
      repeat (2) step();
      check("shadow_hold_crv", cnt_reset_value, exp_crv);
      cnt_strobe = 1'b1;
      step();
      cnt_strobe = 1'b0;
      check("shadow_apply_crv", cnt_reset_value, 3);
      check("shadow_apply_ready", period_ready, 1);

      // Randomized traffic with occasional mid-run resets.
      for (int c = 0; c < 1500; c++) begin
         evt          = 1'($urandom_range(0, 1));
         period_valid = ($urandom_range(0, 7) == 0);
         period_data  = 4'($urandom_range(0, 15));
         cnt_ready    = ($urandom_range(0, 3) != 0);
         cnt_strobe   = ($urandom_range(0, 5) == 0);
         cnt_valid    = ($urandom_range(0, 3) != 0);
         if (c == 500 || c == 1000) mid_reset();
         else step();
      end

      evt = 1'b0;
      period_valid = 1'b0;
      cnt_strobe = 1'b0;
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/strobe_period_controller.md
STROBE_PERIOD_CONTROLLER -- requirements
Module: strobe_period_controller

Interface
REQ-001 Parameter WIDTH, default 16, width of period and cnt_reset_value; SHALL match the downstream strobe counter.
REQ-002 Parameter EVT_W, default 4, width of the pending-event counter.
REQ-003 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 evt  input  1  one count request per cycle high.
REQ-006 period_data  input  WIDTH  requested strobe period.
REQ-007 period_valid  input  1  period_data offered.
REQ-008 period_ready  output  1  period transfer occurs when period_valid && period_ready.
REQ-009 cnt_ready  input  1  counter can accept an enable this cycle.
REQ-010 cnt_strobe, cnt_valid  input  1 each  counter strobe and its qualifier.
REQ-011 cnt_enable  output  1  registered one-cycle enable pulse to the counter.
REQ-012 cnt_reset_value  output  WIDTH  registered period driven to the counter.
REQ-013 tick  output  1  registered, qualified strobe.
REQ-014 evt_overflow  output  1  one-cycle pulse, event dropped.
REQ-015 period_err  output  1  one-cycle pulse, illegal period rejected.

Function
REQ-016 The FSM SHALL have two states, IDLE (no period loaded) and RUN (period loaded).
REQ-017 In IDLE: period_ready=1 and cnt_enable=0; evt SHALL still accumulate into pending.
REQ-018 IDLE->RUN on an accepted legal period; cnt_reset_value SHALL update on that same edge.
REQ-019 In RUN: period_ready = !shadow_full; an accepted period SHALL go to a one-entry shadow register.
REQ-020 Shadow apply: cnt_reset_value <= shadow on the edge where cnt_strobe=1; shadow SHALL clear on that edge.
REQ-021 A transfer on the apply edge SHALL NOT occur, because period_ready=0 while the shadow is full.
REQ-022 cnt_reset_value SHALL NOT change at any other time while in RUN.
REQ-023 pending SHALL be an EVT_W-bit counter: +1 on evt, -1 on each issued enable, net 0 when both occur together.
REQ-024 pending saturates at 2^EVT_W-1; evt while saturated with no enable issued that cycle SHALL pulse evt_overflow and drop the event.
REQ-025 In RUN with pending>0, cnt_ready=1 and cnt_enable=0: cnt_enable SHALL be 1 for exactly the next cycle.
REQ-026 cnt_enable SHALL never be high for two consecutive cycles.
REQ-027 cnt_enable SHALL never be high while cnt_ready was 0 on the issuing edge.
REQ-028 tick <= cnt_strobe && cnt_valid, one cycle latency.
REQ-029 A period below 2 is illegal; its handling is set by REQ-033.

Reset
REQ-030 On rst=1, without waiting for a clock edge: state=IDLE; pending=0; shadow empty; cnt_enable=0; cnt_reset_value=0; tick=0; evt_overflow=0; period_err=0.
REQ-031 After reset release: period_ready=1 on the first cycle.
REQ-032 Reset mid-operation SHALL discard the shadow and all pending events, with no enable issued.

Configuration
REQ-033 Macro PERIOD_CTRL_CLAMP_EN:
- Defined: an illegal period is accepted as 2; period_err stays 0.
- Undefined: an illegal period completes the handshake, is discarded and pulses period_err for one cycle; state, shadow and cnt_reset_value are unchanged.

Verification (WIDTH=4, EVT_W=2, counter model LATENCY=4)
REQ-034 Load period 5, hold evt=1 for 60 cycles -> cnt_enable single-cycle pulses, each preceded by cnt_ready=1; tick after every 5th enable.
REQ-035 Period 5 running, offer 3 after 2 enables -> period_ready drops; cnt_reset_value=3 only from the strobe edge; following ticks every 3 enables.
REQ-036 cnt_ready=0, 5 single evt pulses in RUN -> pending=3, evt_overflow pulses twice, then 3 enables once cnt_ready=1.
REQ-037 Offer period_data=1 -> with macro: cnt_reset_value=2; without: period_err=1 for one cycle and cnt_reset_value unchanged.
REQ-038 Assert rst between clock edges mid-run -> cnt_enable, tick and cnt_reset_value are 0 before the next edge; period_ready=1 after release.
